// File: rtl/register_file_rename_pkg.sv
// Shared constants for the renamed architectural register file.
package register_file_rename_pkg;

    localparam int ROB_BITS_DEF = 4;
    localparam int REG_NUM      = 32;
    localparam int REG_ADDR_W   = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/register_file_rename_read_port.sv
// One read port: stored-state lookup plus forwarding of a same-cycle matching commit.
module regfile_read_port
    import register_file_rename_pkg::*;
#(
    parameter int ROB_BITS = ROB_BITS_DEF
) (
    input  logic                  i_rdy,
    input  logic [REG_ADDR_W-1:0] i_rs_id,
    input  logic [31:0]           i_value [0:REG_NUM-1],
    input  logic                  i_busy  [0:REG_NUM-1],
    input  logic [ROB_BITS-1:0]   i_tag   [0:REG_NUM-1],
    input  logic [REG_ADDR_W-1:0] i_commit_rd,
    input  logic [31:0]           i_commit_value,
    input  logic [ROB_BITS-1:0]   i_commit_tag,
    output logic [31:0]           o_value,
    output logic                  o_busy,
    output logic [ROB_BITS-1:0]   o_tag
);

    logic                w_busy;
    logic [ROB_BITS-1:0] w_tag;
    logic                w_fwd;

    assign w_busy = i_busy[i_rs_id];
    assign w_tag  = i_tag[i_rs_id];

    // Only a commit that actually releases the tag is forwarded; a stale commit is invisible.
    assign w_fwd = i_rdy && (i_rs_id != ZERO_REG) && (i_rs_id == i_commit_rd)
                   && w_busy && (w_tag == i_commit_tag);

    always_comb begin
        o_value = i_value[i_rs_id];
        o_busy  = w_busy;
        o_tag   = w_tag;
        if (i_rs_id == ZERO_REG) begin
            o_value = '0;
            o_busy  = 1'b0;
            o_tag   = '0;
        end else if (w_fwd) begin
            o_value = i_commit_value;
            o_busy  = 1'b0;
            o_tag   = '0;
        end
    end

endmodule

// File: rtl/register_file_rename.sv
// Architectural register file with per-register RoB rename tags and two forwarding read ports.
module register_file_rename
    import register_file_rename_pkg::*;
#(
    parameter int ROB_BITS = ROB_BITS_DEF
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [ROB_BITS-1:0]   issue_tag,
    input  logic [REG_ADDR_W-1:0] commit_rd,
    input  logic [31:0]           commit_value,
    input  logic [ROB_BITS-1:0]   commit_tag,
    input  logic                  rob_clear,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    output logic [31:0]           rs1_value,
    output logic                  rs1_busy,
    output logic [ROB_BITS-1:0]   rs1_tag,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    output logic [31:0]           rs2_value,
    output logic                  rs2_busy,
    output logic [ROB_BITS-1:0]   rs2_tag
);

    logic [31:0]         r_value [0:REG_NUM-1];
    logic                r_busy  [0:REG_NUM-1];
    logic [ROB_BITS-1:0] r_tag   [0:REG_NUM-1];

    // Per-register update; later assignments override earlier ones, giving clear > issue > commit.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_value[i] <= '0;
                r_busy[i]  <= 1'b0;
                r_tag[i]   <= '0;
            end
        end else if (rdy_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                if (i != 0) begin
                    if (commit_rd == REG_ADDR_W'(i)) begin
                        r_value[i] <= commit_value;
                        if (r_busy[i] && (r_tag[i] == commit_tag)) begin
                            r_busy[i] <= 1'b0;
                            r_tag[i]  <= '0;
                        end
                    end
                    if (rob_clear) begin
                        r_busy[i] <= 1'b0;
                        r_tag[i]  <= '0;
                    end else if (issue_rd == REG_ADDR_W'(i)) begin
                        r_busy[i] <= 1'b1;
                        r_tag[i]  <= issue_tag;
                    end
                end
            end
        end
    end

    regfile_read_port #(.ROB_BITS(ROB_BITS)) u_rd_port1 (
        .i_rdy          (rdy_in),
        .i_rs_id        (rs1_id),
        .i_value        (r_value),
        .i_busy         (r_busy),
        .i_tag          (r_tag),
        .i_commit_rd    (commit_rd),
        .i_commit_value (commit_value),
        .i_commit_tag   (commit_tag),
        .o_value        (rs1_value),
        .o_busy         (rs1_busy),
        .o_tag          (rs1_tag)
    );

    regfile_read_port #(.ROB_BITS(ROB_BITS)) u_rd_port2 (
        .i_rdy          (rdy_in),
        .i_rs_id        (rs2_id),
        .i_value        (r_value),
        .i_busy         (r_busy),
        .i_tag          (r_tag),
        .i_commit_rd    (commit_rd),
        .i_commit_value (commit_value),
        .i_commit_tag   (commit_tag),
        .o_value        (rs2_value),
        .o_busy         (rs2_busy),
        .o_tag          (rs2_tag)
    );

endmodule

// File: tb/tb_register_file_rename.sv
// Directed self-checking bench for register_file_rename.
module tb_register_file_rename;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_tag;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic [3:0]  commit_tag;
    logic        rob_clear;
    logic [4:0]  rs1_id;
    logic [31:0] rs1_value;
    logic        rs1_busy;
    logic [3:0]  rs1_tag;
    logic [4:0]  rs2_id;
    logic [31:0] rs2_value;
    logic        rs2_busy;
    logic [3:0]  rs2_tag;

    int n_checks = 0;
    int n_fail   = 0;

    register_file_rename #(.ROB_BITS(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_rd(issue_rd), .issue_tag(issue_tag),
        .commit_rd(commit_rd), .commit_value(commit_value), .commit_tag(commit_tag),
        .rob_clear(rob_clear),
        .rs1_id(rs1_id), .rs1_value(rs1_value), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
        .rs2_id(rs2_id), .rs2_value(rs2_value), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic idle_inputs();
        issue_rd = 0; issue_tag = 0; commit_rd = 0; commit_value = 0; commit_tag = 0;
        rob_clear = 0;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        idle_inputs();
        #1;
    endtask

    task automatic test_reset_initial();
        rst_in = 0; rdy_in = 1; idle_inputs(); rs1_id = 5; rs2_id = 31;
        repeat (2) @(posedge clk_in);
        #1;
        n_checks++;
        if (rs1_value !== 32'd0 || rs1_busy !== 1'b0 || rs1_tag !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_init_rs1: got v=%h b=%b t=%h exp v=0 b=0 t=0", rs1_value, rs1_busy, rs1_tag);
        end
        n_checks++;
        if (rs2_value !== 32'd0 || rs2_busy !== 1'b0 || rs2_tag !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_init_rs2: got v=%h b=%b t=%h exp v=0 b=0 t=0", rs2_value, rs2_busy, rs2_tag);
        end
        rst_in = 1;
        step();
    endtask

    task automatic test_issue_commit();
        issue_rd = 3; issue_tag = 2;
        step();
        rs1_id = 3; #1;
        n_checks++;
        if (rs1_busy !== 1'b1 || rs1_tag !== 4'd2 || rs1_value !== 32'd0) begin
            n_fail++;
            $display("FAIL issue_busy: got v=%h b=%b t=%h exp v=0 b=1 t=2", rs1_value, rs1_busy, rs1_tag);
        end
        commit_rd = 3; commit_tag = 2; commit_value = 32'h1234; #1;
        n_checks++;
        if (rs1_value !== 32'h1234 || rs1_busy !== 1'b0 || rs1_tag !== 4'd0) begin
            n_fail++;
            $display("FAIL commit_forward: got v=%h b=%b t=%h exp v=1234 b=0 t=0", rs1_value, rs1_busy, rs1_tag);
        end
        step();
        n_checks++;
        if (rs1_value !== 32'h1234 || rs1_busy !== 1'b0 || rs1_tag !== 4'd0) begin
            n_fail++;
            $display("FAIL commit_stored: got v=%h b=%b t=%h exp v=1234 b=0 t=0", rs1_value, rs1_busy, rs1_tag);
        end
    endtask

    task automatic test_stale_commit();
        issue_rd = 3; issue_tag = 2;
        step();
        issue_rd = 3; issue_tag = 5;
        step();
        rs1_id = 3;
        commit_rd = 3; commit_tag = 2; commit_value = 32'hAA; #1;
        n_checks++;
        if (rs1_value !== 32'h1234 || rs1_busy !== 1'b1 || rs1_tag !== 4'd5) begin
            n_fail++;
            $display("FAIL stale_no_forward: got v=%h b=%b t=%h exp v=1234 b=1 t=5", rs1_value, rs1_busy, rs1_tag);
        end
        step();
        n_checks++;
        if (rs1_value !== 32'hAA || rs1_busy !== 1'b1 || rs1_tag !== 4'd5) begin
            n_fail++;
            $display("FAIL stale_stored: got v=%h b=%b t=%h exp v=aa b=1 t=5", rs1_value, rs1_busy, rs1_tag);
        end
    endtask

    task automatic test_same_cycle_issue_commit();
        issue_rd = 7; issue_tag = 1;
        step();
        rs2_id = 7;
        issue_rd = 7; issue_tag = 4;
        commit_rd = 7; commit_tag = 1; commit_value = 32'hBEEF; #1;
        n_checks++;
        if (rs2_value !== 32'hBEEF || rs2_busy !== 1'b0 || rs2_tag !== 4'd0) begin
            n_fail++;
            $display("FAIL same_cycle_forward: got v=%h b=%b t=%h exp v=beef b=0 t=0", rs2_value, rs2_busy, rs2_tag);
        end
        step();
        n_checks++;
        if (rs2_value !== 32'hBEEF || rs2_busy !== 1'b1 || rs2_tag !== 4'd4) begin
            n_fail++;
            $display("FAIL same_cycle_stored: got v=%h b=%b t=%h exp v=beef b=1 t=4", rs2_value, rs2_busy, rs2_tag);
        end
    endtask

    task automatic test_rob_clear();
        issue_rd = 2; issue_tag = 3;
        step();
        issue_rd = 9; issue_tag = 7;
        step();
        rob_clear = 1; commit_rd = 1; commit_value = 32'h80; commit_tag = 0;
        issue_rd = 4; issue_tag = 6;
        step();
        rs1_id = 2; rs2_id = 9; #1;
        n_checks++;
        if (rs1_busy !== 1'b0 || rs1_tag !== 4'd0 || rs2_busy !== 1'b0 || rs2_tag !== 4'd0) begin
            n_fail++;
            $display("FAIL clear_busy_x2_x9: got b2=%b t2=%h b9=%b t9=%h exp all 0", rs1_busy, rs1_tag, rs2_busy, rs2_tag);
        end
        rs1_id = 1; rs2_id = 4; #1;
        n_checks++;
        if (rs1_value !== 32'h80 || rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_commit_x1: got v=%h b=%b exp v=80 b=0", rs1_value, rs1_busy);
        end
        n_checks++;
        if (rs2_busy !== 1'b0 || rs2_tag !== 4'd0) begin
            n_fail++;
            $display("FAIL clear_issue_ignored_x4: got b=%b t=%h exp b=0 t=0", rs2_busy, rs2_tag);
        end
        rs1_id = 3; rs2_id = 7; #1;
        n_checks++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_busy_x3_x7: got b3=%b b7=%b exp 0 0", rs1_busy, rs2_busy);
        end
    endtask

    task automatic test_x0_and_rdy();
        commit_rd = 0; commit_value = 32'hFFFF; issue_rd = 0; issue_tag = 3;
        rs1_id = 0; #1;
        n_checks++;
        if (rs1_value !== 32'd0 || rs1_busy !== 1'b0 || rs1_tag !== 4'd0) begin
            n_fail++;
            $display("FAIL x0_same_cycle: got v=%h b=%b t=%h exp 0 0 0", rs1_value, rs1_busy, rs1_tag);
        end
        step();
        n_checks++;
        if (rs1_value !== 32'd0 || rs1_busy !== 1'b0 || rs1_tag !== 4'd0) begin
            n_fail++;
            $display("FAIL x0_after: got v=%h b=%b t=%h exp 0 0 0", rs1_value, rs1_busy, rs1_tag);
        end
        rdy_in = 0;
        commit_rd = 8; commit_value = 32'h55; issue_rd = 10; issue_tag = 9;
        step();
        rdy_in = 1;
        rs1_id = 8; rs2_id = 10; #1;
        n_checks++;
        if (rs1_value !== 32'd0) begin
            n_fail++;
            $display("FAIL rdy_low_commit: got v=%h exp v=0", rs1_value);
        end
        n_checks++;
        if (rs2_busy !== 1'b0 || rs2_tag !== 4'd0) begin
            n_fail++;
            $display("FAIL rdy_low_issue: got b=%b t=%h exp b=0 t=0", rs2_busy, rs2_tag);
        end
        // x7 holds busy tag 4 from earlier? no: cleared. Re-rename it, then probe forwarding with rdy low.
        issue_rd = 7; issue_tag = 4;
        step();
        rdy_in = 0; rs2_id = 7;
        commit_rd = 7; commit_tag = 4; commit_value = 32'h777; #1;
        n_checks++;
        if (rs2_value !== 32'hBEEF || rs2_busy !== 1'b1 || rs2_tag !== 4'd4) begin
            n_fail++;
            $display("FAIL rdy_low_no_forward: got v=%h b=%b t=%h exp v=beef b=1 t=4", rs2_value, rs2_busy, rs2_tag);
        end
        step();
        rdy_in = 1;
    endtask

    task automatic test_reset_midrun();
        issue_rd = 5; issue_tag = 9;
        step();
        rs1_id = 5; rs2_id = 1; #1;
        n_checks++;
        if (rs1_busy !== 1'b1 || rs1_tag !== 4'd9) begin
            n_fail++;
            $display("FAIL midrun_pre_busy: got b=%b t=%h exp b=1 t=9", rs1_busy, rs1_tag);
        end
        rst_in = 0; #1;
        n_checks++;
        if (rs1_value !== 32'd0 || rs1_busy !== 1'b0 || rs1_tag !== 4'd0) begin
            n_fail++;
            $display("FAIL midrun_reset_x5: got v=%h b=%b t=%h exp 0 0 0", rs1_value, rs1_busy, rs1_tag);
        end
        n_checks++;
        if (rs2_value !== 32'd0) begin
            n_fail++;
            $display("FAIL midrun_reset_x1: got v=%h exp 0", rs2_value);
        end
        step();
        rst_in = 1;
        step();
    endtask

    initial begin
        test_reset_initial();
        test_issue_commit();
        test_stale_commit();
        test_same_cycle_issue_commit();
        test_rob_clear();
        test_x0_and_rdy();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
